// File: rtl/bcd_to_bin_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
// Holds the digit count, result width, iteration count, FSM state
// encodings and a helper that spots non-BCD digits.
package bcd_to_bin_pkg;

    localparam int DIGITS  = 4;
    localparam int BIN_W   = 14;
    localparam int BCD_W   = DIGITS * 4;
    localparam int ITER    = 14;
    localparam int MAX_DEC = 9999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    // True when any packed digit holds a value above 9.
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[d*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Handshake/data bundle for the BCD-to-binary converter.
//   start   : request a conversion (master -> slave)
//   bcd_in  : packed BCD operand, digit3 in the top nibble
//   bin_out : converted value, held until the next done
//   busy    : conversion in progress
//   done    : one-cycle pulse marking bin_out/err valid
//   err     : last conversion saw a digit above 9
interface bcd_to_bin_if;
    import bcd_to_bin_pkg::*;

    logic             start;
    logic [BCD_W-1:0] bcd_in;
    logic [BIN_W-1:0] bin_out;
    logic             busy;
    logic             done;
    logic             err;

    modport master (output start, bcd_in, input bin_out, busy, done, err);
    modport slave  (input start, bcd_in, output bin_out, busy, done, err);

endinterface

// File: rtl/bcd_to_bin_digit_adjust.sv
// Per-digit correction for reverse double-dabble.
//   in  : 4-bit digit after the right shift
//   out : in - 3 when in >= 8, otherwise in unchanged
// A shifted-in weight-10 bit lands as 8 in the lower digit; taking 3
// off leaves 5, which is the correct half of 10 in decimal.
module bcd_digit_adjust (
    input  logic [3:0] in,
    output logic [3:0] out
);

    assign out = (in >= 4'd8) ? in - 4'd3 : in;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 4-digit packed-BCD to binary converter (reverse double-dabble).
// One right shift of {digit_reg, acc} per cycle followed by per-digit
// correction; 14 iterations then a one-cycle FIN that publishes results.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : start/bcd_in in, bin_out/busy/done/err out (all registered)
module bcd_to_bin
    import bcd_to_bin_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    bcd_to_bin_if.slave    bus
);

    localparam logic [3:0] LAST_ITER = 4'(ITER - 1);

    state_t           state;
    logic [BCD_W-1:0] digit_reg;
    logic [BIN_W-1:0] acc;
    logic [3:0]       cnt;
    logic             err_flag;

    // Shift stage: digit_reg LSB falls into the accumulator MSB.
    logic [BCD_W-1:0] dig_shift;
    logic [BCD_W-1:0] dig_adj;
    logic [BIN_W-1:0] acc_shift;

    assign dig_shift = {1'b0, digit_reg[BCD_W-1:1]};
    assign acc_shift = {digit_reg[0], acc[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .in  (dig_shift[g*4 +: 4]),
            .out (dig_adj[g*4 +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            digit_reg   <= '0;
            acc         <= '0;
            cnt         <= '0;
            err_flag    <= 1'b0;
            bus.bin_out <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        digit_reg <= bus.bcd_in;
                        acc       <= '0;
                        cnt       <= '0;
                        bus.busy  <= 1'b1;
                        // Bad digits skip the shift loop entirely.
                        err_flag  <= has_bad_digit(bus.bcd_in);
                        state     <= has_bad_digit(bus.bcd_in) ? FIN : CONV;
                    end
                end
                CONV: begin
                    digit_reg <= dig_adj;
                    acc       <= acc_shift;
                    cnt       <= cnt + 4'd1;
                    if (cnt == LAST_ITER) state <= FIN;
                end
                FIN: begin
                    bus.bin_out <= err_flag ? '0 : acc;
                    bus.err     <= err_flag;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every BCD weight must have drained into acc by the end of the loop.
    a_digits_drained: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == FIN && !err_flag) |-> (digit_reg == '0)
    );

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: checks reset state, valid and error
// conversions, latency/busy width, start ignored while busy, operand
// changes after accept, and reset abort mid-conversion.
module tb_bcd_to_bin;
    import bcd_to_bin_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    bcd_to_bin_if bus ();

    bcd_to_bin dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One conversion. glitch pulses start over edges E3..E10;
    // abort pulls rst_n low just before E7 and returns without a done.
    task automatic run(input string tag, input logic [15:0] v, input int exp_bin,
                       input bit exp_err, input bit glitch, input bit abort);
        int n;
        int busy_cnt;
        bit seen;
        int lat;
        lat = exp_err ? 1 : 15;
        @(negedge clk);
        bus.bcd_in = v;
        bus.start  = 1'b1;
        @(posedge clk);                 // E0
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = 16'hFFFF;          // must not disturb the running conversion
        @(negedge clk);
        chk({tag, "_busy_e0"}, 32'(bus.busy), 32'd1);
        busy_cnt = int'(bus.busy);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (glitch) bus.start = (n >= 2 && n <= 9);
            if (abort && n == 6) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_abort_outs"},
                    {15'd0, bus.busy, bus.done, bus.err, bus.bin_out}, 32'd0);
                repeat (3) @(negedge clk);
                chk({tag, "_abort_nodone"}, 32'(bus.done), 32'd0);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else busy_cnt += int'(bus.busy);
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
        chk({tag, "_bin"}, 32'(bus.bin_out), 32'(exp_bin));
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        if (glitch) begin
            repeat (3) @(negedge clk);
            chk({tag, "_no_extra"}, {30'd0, bus.busy, bus.done}, 32'd0);
            chk({tag, "_bin_held"}, 32'(bus.bin_out), 32'(exp_bin));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.bcd_in  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {15'd0, bus.busy, bus.done, bus.err, bus.bin_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", {15'd0, bus.busy, bus.done, bus.err, bus.bin_out}, 32'd0);

        run("zero",   16'h0000, 0,    1'b0, 1'b0, 1'b0);
        run("v1234",  16'h1234, 1234, 1'b0, 1'b0, 1'b0);
        run("v9999",  16'h9999, 9999, 1'b0, 1'b0, 1'b0);
        run("bad12A4", 16'h12A4, 0,   1'b1, 1'b0, 1'b0);
        run("v0042",  16'h0042, 42,   1'b0, 1'b0, 1'b0);
        run("badF000", 16'hF000, 0,   1'b1, 1'b0, 1'b0);
        run("v0500",  16'h0500, 500,  1'b0, 1'b1, 1'b0);
        run("abort",  16'h8765, 0,    1'b0, 1'b0, 1'b1);
        run("v8765",  16'h8765, 8765, 1'b0, 1'b0, 1'b0);
        run("v1000",  16'h1000, 1000, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
